// File: rtl/btn_debounce_multi.sv
// btn_debounce_multi
//   Multi-channel push-button conditioner. Each channel is synchronized into
//   clk, then debounced: a change is accepted only after it has been seen for
//   DEBOUNCE_CYCLES consecutive cycles at the synchronizer output. Accepted
//   presses/releases produce one-cycle pulses, and presses on channels
//   selected by TX_MASK request a UART transmission.
//
// Ports
//   clk        single clock, all flops on rising edge
//   rst_n      asynchronous active-low reset
//   btn_in     raw asynchronous button inputs, N_CH bits
//   btn_level  debounced level per channel, 1 = pressed
//   btn_rise   one-cycle pulse per accepted press
//   btn_fall   one-cycle pulse per accepted release
//   tx_start   one-cycle request, OR of masked accepted presses
module btn_debounce_multi #(
    parameter int              N_CH            = 4,
    parameter int              DEBOUNCE_CYCLES = 1000000,
    parameter int              SYNC_STAGES     = 2,
    parameter int              ACTIVE_LOW      = 0,
    parameter logic [N_CH-1:0] TX_MASK         = {N_CH{1'b1}}
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] btn_in,
    output logic [N_CH-1:0] btn_level,
    output logic [N_CH-1:0] btn_rise,
    output logic [N_CH-1:0] btn_fall,
    output logic            tx_start
);

    localparam int             CW      = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0][N_CH-1:0] sync_q, sync_d;
    logic [N_CH-1:0][CW-1:0]          cnt_q, cnt_d;
    logic [N_CH-1:0]                  level_q, level_d;
    logic [N_CH-1:0]                  rise_q, rise_d;
    logic [N_CH-1:0]                  fall_q, fall_d;
    logic                             tx_q, tx_d;
    logic [N_CH-1:0]                  s;

    // Polarity is normalised before the first flop so that everything
    // downstream sees 1 = pressed.
    always_comb begin
        sync_d    = '0;
        sync_d[0] = (ACTIVE_LOW != 0) ? ~btn_in : btn_in;
        for (int k = 1; k < SYNC_STAGES; k++) begin
            sync_d[k] = sync_q[k-1];
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // The counter measures how long s has disagreed with the accepted level;
    // any agreement restarts the measurement, so short glitches vanish.
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        rise_d  = '0;
        fall_d  = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (s[i] == level_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_MAX) begin
                cnt_d[i]   = '0;
                level_d[i] = s[i];
                rise_d[i]  = s[i];
                fall_d[i]  = ~s[i];
            end else begin
                cnt_d[i] = cnt_q[i] + CW'(1);
            end
        end
        // Computed from rise_d so the request lands in the same cycle as the
        // registered rise pulse.
        tx_d = |(rise_d & TX_MASK);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
            tx_q    <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            tx_q    <= tx_d;
        end
    end

    assign btn_level = level_q;
    assign btn_rise  = rise_q;
    assign btn_fall  = fall_q;
    assign tx_start  = tx_q;

endmodule

// File: tb/tb_btn_debounce_multi.sv
// Testbench for btn_debounce_multi: one active-high instance with TX_MASK
// 4'b0001 and one ACTIVE_LOW instance, both with DEBOUNCE_CYCLES=4 and
// SYNC_STAGES=2, driven by directed vectors.
module tb_btn_debounce_multi;

    logic       clk;
    logic       rst_a, rst_b;
    logic [3:0] btn_a, btn_b;
    logic [3:0] lvl_a, rise_a, fall_a;
    logic [3:0] lvl_b, rise_b, fall_b;
    logic       tx_a, tx_b;

    int n_checks = 0;
    int n_errors = 0;

    btn_debounce_multi #(
        .N_CH(4), .DEBOUNCE_CYCLES(4), .SYNC_STAGES(2),
        .ACTIVE_LOW(0), .TX_MASK(4'b0001)
    ) u_dut_a (
        .clk(clk), .rst_n(rst_a), .btn_in(btn_a),
        .btn_level(lvl_a), .btn_rise(rise_a), .btn_fall(fall_a),
        .tx_start(tx_a)
    );

    btn_debounce_multi #(
        .N_CH(4), .DEBOUNCE_CYCLES(4), .SYNC_STAGES(2),
        .ACTIVE_LOW(1)
    ) u_dut_b (
        .clk(clk), .rst_n(rst_b), .btn_in(btn_b),
        .btn_level(lvl_b), .btn_rise(rise_b), .btn_fall(fall_b),
        .tx_start(tx_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_a = 1'b0;
        rst_b = 1'b0;
        btn_a = 4'h0;
        btn_b = 4'hF;

        // reset state
        repeat (3) begin
            tick();
            check_eq("rst_lvl_a",  32'(lvl_a),  32'h0);
            check_eq("rst_rise_a", 32'(rise_a), 32'h0);
            check_eq("rst_fall_a", 32'(fall_a), 32'h0);
            check_eq("rst_tx_a",   32'(tx_a),   32'h0);
            check_eq("rst_lvl_b",  32'(lvl_b),  32'h0);
        end
        rst_a = 1'b1;
        rst_b = 1'b1;
        repeat (2) tick();

        // clean press on ch0
        btn_a = 4'h1;
        for (int i = 1; i <= 7; i++) begin
            tick();
            check_eq("press_lvl",  32'(lvl_a),  (i >= 6) ? 32'h1 : 32'h0);
            check_eq("press_rise", 32'(rise_a), (i == 6) ? 32'h1 : 32'h0);
            check_eq("press_tx",   32'(tx_a),   (i == 6) ? 32'h1 : 32'h0);
        end

        // release ch0
        btn_a = 4'h0;
        for (int i = 1; i <= 7; i++) begin
            tick();
            check_eq("rel_lvl",  32'(lvl_a),  (i >= 6) ? 32'h0 : 32'h1);
            check_eq("rel_fall", 32'(fall_a), (i == 6) ? 32'h1 : 32'h0);
            check_eq("rel_rise", 32'(rise_a), 32'h0);
            check_eq("rel_tx",   32'(tx_a),   32'h0);
        end

        // bounce on ch1: high for three sampled cycles, one short of acceptance
        btn_a = 4'h2;
        for (int i = 1; i <= 10; i++) begin
            if (i == 4) btn_a = 4'h0;
            tick();
            check_eq("bnc_lvl",  32'(lvl_a),  32'h0);
            check_eq("bnc_rise", 32'(rise_a), 32'h0);
            check_eq("bnc_tx",   32'(tx_a),   32'h0);
        end

        // simultaneous press on ch0 and ch3
        btn_a = 4'h9;
        for (int i = 1; i <= 7; i++) begin
            tick();
            check_eq("sim_lvl",  32'(lvl_a),  (i >= 6) ? 32'h9 : 32'h0);
            check_eq("sim_rise", 32'(rise_a), (i == 6) ? 32'h9 : 32'h0);
            check_eq("sim_tx",   32'(tx_a),   (i == 6) ? 32'h1 : 32'h0);
        end

        // release ch0 only, ch3 stays pressed
        btn_a = 4'h8;
        for (int i = 1; i <= 7; i++) begin
            tick();
            check_eq("rel0_lvl",  32'(lvl_a),  (i >= 6) ? 32'h8 : 32'h9);
            check_eq("rel0_fall", 32'(fall_a), (i == 6) ? 32'h1 : 32'h0);
            check_eq("rel0_tx",   32'(tx_a),   32'h0);
        end

        // reset mid-count on ch2 (counter at 2 after four edges)
        btn_a = 4'hC;
        for (int i = 1; i <= 4; i++) begin
            tick();
            check_eq("mid_lvl",  32'(lvl_a),  32'h8);
            check_eq("mid_rise", 32'(rise_a), 32'h0);
        end
        rst_a = 1'b0;
        #2;
        check_eq("async_lvl",  32'(lvl_a),  32'h0);
        check_eq("async_rise", 32'(rise_a), 32'h0);
        check_eq("async_fall", 32'(fall_a), 32'h0);
        check_eq("async_tx",   32'(tx_a),   32'h0);
        for (int i = 1; i <= 3; i++) begin
            tick();
            check_eq("inrst_lvl",  32'(lvl_a),  32'h0);
            check_eq("inrst_rise", 32'(rise_a), 32'h0);
        end
        rst_a = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            tick();
            check_eq("post_lvl",  32'(lvl_a),  (i >= 6) ? 32'hC : 32'h0);
            check_eq("post_rise", 32'(rise_a), (i == 6) ? 32'hC : 32'h0);
            check_eq("post_tx",   32'(tx_a),   32'h0);
        end

        // active-low instance: held at 4'b1111 all along, nothing accepted
        check_eq("al_idle_lvl",  32'(lvl_b),  32'h0);
        check_eq("al_idle_rise", 32'(rise_b), 32'h0);
        btn_b = 4'hE;
        for (int i = 1; i <= 7; i++) begin
            tick();
            check_eq("al_lvl",  32'(lvl_b),  (i >= 6) ? 32'h1 : 32'h0);
            check_eq("al_rise", 32'(rise_b), (i == 6) ? 32'h1 : 32'h0);
            check_eq("al_tx",   32'(tx_b),   (i == 6) ? 32'h1 : 32'h0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/btn_debounce_multi.md
BTN_DEBOUNCE_MULTI -- requirements
Module: btn_debounce_multi

Interface
REQ-001 The block SHALL have parameter N_CH, default 4: number of independent button channels (1..32).
REQ-002 The block SHALL have parameter DEBOUNCE_CYCLES, default 1000000: consecutive stable cycles required to accept a change (>=2; 10 ms at 100 MHz).
REQ-003 The block SHALL have parameter SYNC_STAGES, default 2: synchronizer flops per channel (>=2).
REQ-004 The block SHALL have parameter ACTIVE_LOW, default 0: when 1, btn_in is inverted before synchronization.
REQ-005 The block SHALL have parameter TX_MASK, default {N_CH{1'b1}}: channels whose accepted press raises tx_start.
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock; all flops on its rising edge.
REQ-007 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-008 The block SHALL have port btn_in, input, N_CH bits: raw asynchronous button inputs.
REQ-009 The block SHALL have port btn_level, output, N_CH bits: debounced level per channel, 1 = pressed.
REQ-010 The block SHALL have port btn_rise, output, N_CH bits: one-cycle pulse per accepted press.
REQ-011 The block SHALL have port btn_fall, output, N_CH bits: one-cycle pulse per accepted release.
REQ-012 The block SHALL have port tx_start, output, 1 bit: one-cycle request to the UART transmitter.

Function
REQ-013 Each channel SHALL pass btn_in (inverted if ACTIVE_LOW) through SYNC_STAGES flops; the last stage is s[i].
REQ-014 Each channel SHALL own a counter of width $clog2(DEBOUNCE_CYCLES) and registered btn_level[i].
REQ-015 When s[i] == btn_level[i], the counter SHALL be cleared to 0 on the next edge.
REQ-016 When s[i] != btn_level[i] and counter < DEBOUNCE_CYCLES-1, the counter SHALL increment by 1.
REQ-017 When s[i] != btn_level[i] and counter == DEBOUNCE_CYCLES-1, btn_level[i] SHALL take s[i] and the counter SHALL clear; the counter never wraps.
REQ-018 A change shorter than DEBOUNCE_CYCLES consecutive cycles at s[i] SHALL be discarded: no level change, no pulse.
REQ-019 Latency: a clean input change held stable SHALL appear on btn_level exactly SYNC_STAGES+DEBOUNCE_CYCLES rising edges after the first edge that samples it.
REQ-020 btn_rise[i]/btn_fall[i] SHALL be registered, asserted in the same cycle btn_level[i] changes to 1/0, for exactly one cycle.
REQ-021 Channels SHALL be fully independent; simultaneous events on several channels SHALL each produce their own pulses in the same cycle.
REQ-022 tx_start SHALL equal |(btn_rise & TX_MASK): one cycle, coincident with the rise; several simultaneous masked rises SHALL yield one single-cycle pulse.
REQ-023 btn_fall SHALL never drive tx_start.

Reset
REQ-024 rst_n low SHALL immediately clear all synchronizer flops, counters, btn_level, btn_rise, btn_fall and tx_start to 0, regardless of clk.
REQ-025 Reset asserted mid-count SHALL abandon the pending change; no pulse SHALL be emitted for it.
REQ-026 After rst_n rises, an input held pressed throughout reset SHALL be accepted as a new press after SYNC_STAGES+DEBOUNCE_CYCLES edges, emitting btn_rise.

Verification (N_CH=4, DEBOUNCE_CYCLES=4, SYNC_STAGES=2, TX_MASK=4'b0001 unless stated)
REQ-027 Clean press: btn_in[0] 0->1 held -> btn_level[0]=1 at edge 6 after first sampling edge; btn_rise[0] and tx_start high for that single cycle.
REQ-028 Bounce: btn_in[1] high for 3 cycles then low -> btn_level, btn_rise, tx_start remain 0 throughout.
REQ-029 Release: btn_in[0] 1->0 held -> btn_level[0]=0 at edge 6, btn_fall[0] one-cycle pulse, tx_start stays 0.
REQ-030 Simultaneous: btn_in[0] and btn_in[3] rise on same edge -> btn_rise=4'b1001 for one cycle, tx_start one single-cycle pulse.
REQ-031 Reset mid-count: btn_in[2] high, rst_n low when counter=2 -> all outputs 0 immediately; rst_n high with input still high -> btn_rise[2] at edge 6 after release.
REQ-032 ACTIVE_LOW=1: btn_in=4'b1111 through and after reset -> btn_level stays 0; btn_in[0] driven 0 -> btn_rise[0] at edge 6.
